gate_truth_checker: RTL

- Self-checking harness stage for 2-input primitive gates such as _Nand.
- Sits directly around the gate under test:
  - Upstream: it drives every input combination onto the gate.
  - Downstream: it samples the gate output and compares each sample against an expected truth table.
- Replaces hand-written stimulus/compare sequences with a synthesizable, reusable checker.
- Reports pass/fail, mismatch count and first failing vector.

---
 rtl/gate_truth_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of a small combinational gate, samples its output after a
// settle time and compares it with a truth table, reporting pass, error count and first failing index.
module gate_truth_checker #(
   parameter int                    N_IN   = 2,
   parameter logic [(2**N_IN)-1:0]  EXPECT = 4'b0111,
   parameter int                    SETTLE = 1,
   parameter int                    ERRW   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   vec,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERRW-1:0]   err_cnt,
   output logic              fail_valid,
   output logic [N_IN-1:0]   fail_idx
);

   localparam int              TW       = $clog2(SETTLE + 1);
   localparam logic [TW-1:0]   LAST_T   = TW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
   localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [TW-1:0]     timer_r;
   logic [TW-1:0]     timer_s;
   logic [N_IN-1:0]   vec_s;
   logic              busy_s;
   logic              done_s;
   logic              pass_s;
   logic [ERRW-1:0]   err_s;
   logic              fail_valid_s;
   logic [N_IN-1:0]   fail_idx_s;
   logic              mismatch_s;

   // Compare the sampled gate output with the truth table; X or Z never matches.
   always_comb begin
      mismatch_s = (dut_out !== EXPECT[vec]);
   end

   // Next-state and next-output logic of the sweep controller.
   always_comb begin
      state_s      = state_r;
      timer_s      = timer_r;
      vec_s        = vec;
      busy_s       = busy;
      done_s       = 1'b0;
      pass_s       = pass;
      err_s        = err_cnt;
      fail_valid_s = fail_valid;
      fail_idx_s   = fail_idx;
      case (state_r)
         ST_IDLE: begin
            vec_s  = {N_IN{1'b0}};
            busy_s = 1'b0;
            if (start) begin
               state_s      = ST_RUN;
               busy_s       = 1'b1;
               timer_s      = {TW{1'b0}};
               err_s        = {ERRW{1'b0}};
               fail_valid_s = 1'b0;
               fail_idx_s   = {N_IN{1'b0}};
               pass_s       = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (timer_r == LAST_T) begin
               if (mismatch_s) begin
                  if (err_cnt != ERR_MAX) begin
                     err_s = err_cnt + ERRW'(1);
                  end else begin
                     err_s = err_cnt;
                  end
                  if (!fail_valid) begin
                     fail_valid_s = 1'b1;
                     fail_idx_s   = vec;
                  end else begin
                     fail_valid_s = fail_valid;
                  end
               end else begin
                  err_s = err_cnt;
               end
               // fail_valid still reflects earlier vectors only, so fold in this sample.
               if (vec == LAST_VEC) begin
                  state_s = ST_DONE;
                  busy_s  = 1'b0;
                  vec_s   = {N_IN{1'b0}};
                  done_s  = 1'b1;
                  pass_s  = !fail_valid && !mismatch_s;
               end else begin
                  vec_s   = vec + N_IN'(1);
                  timer_s = {TW{1'b0}};
               end
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            vec_s   = {N_IN{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         timer_r    <= {TW{1'b0}};
         vec        <= {N_IN{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= {ERRW{1'b0}};
         fail_valid <= 1'b0;
         fail_idx   <= {N_IN{1'b0}};
      end else begin
         state_r    <= state_s;
         timer_r    <= timer_s;
         vec        <= vec_s;
         busy       <= busy_s;
         done       <= done_s;
         pass       <= pass_s;
         err_cnt    <= err_s;
         fail_valid <= fail_valid_s;
         fail_idx   <= fail_idx_s;
      end
   end

endmodule
